// File: rtl/multicycle_riscv_pkg.sv
// Shared constants for the multicycle RV32 core: opcodes, ALU op codes, FSM states.
package riscv_pkg;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // {funct7[5], funct3} so R-type and shift-immediate fields map straight through
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_wr_t;

endpackage

// File: rtl/multicycle_riscv_alu.sv
// Combinational 32-bit ALU for the multicycle core.
module mc_alu
  import riscv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = a + b;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/multicycle_riscv.sv
// Multicycle RV32I/E core with a single shared req/ready memory port.
// Define MULTICYCLE_RISCV_PERF_EN to build the cycle / retired-instruction counters.
module multicycle_riscv
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halted,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_instret
);

  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t      state, state_nx;
  logic [31:0] pc, ir, a_q, b_q, alu_out, mdr;
  logic [31:0] rf [NREGS];
  rf_wr_t      rf_wr;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_y, pc_plus4;
  logic [3:0]  alu_op;
  logic        alu_zero, illegal, taken, mem_done;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};

  function automatic logic reg_bad(input logic [4:0] r);
    return int'({27'b0, r}) >= NREGS;
  endfunction

  // out-of-range indices trap in DECODE; the zero here only keeps the read in bounds
  assign rs1_val = (rs1 == 5'd0 || reg_bad(rs1)) ? 32'd0 : rf[rs1[RW-1:0]];
  assign rs2_val = (rs2 == 5'd0 || reg_bad(rs2)) ? 32'd0 : rf[rs2[RW-1:0]];

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OP_LUI, OP_JAL: illegal = reg_bad(rd);
      OP_R: illegal = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                      || reg_bad(rd) || reg_bad(rs1) || reg_bad(rs2);
      OP_I: illegal = (f3 == 3'b001 && f7 != 7'b0)
                      || (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000)
                      || reg_bad(rd) || reg_bad(rs1);
      OP_LW: illegal = (f3 != 3'b010) || reg_bad(rd) || reg_bad(rs1);
      OP_SW: illegal = (f3 != 3'b010) || reg_bad(rs1) || reg_bad(rs2);
      OP_BR: illegal = (f3 != 3'b000 && f3 != 3'b001) || reg_bad(rs1) || reg_bad(rs2);
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu_b  = b_q;
    alu_op = ALU_ADD;
    case (opcode)
      OP_R:  alu_op = {f7[5], f3};
      OP_I: begin
        alu_b  = imm_i;
        alu_op = (f3 == 3'b001 || f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
      end
      OP_LW: alu_b = imm_i;
      OP_SW: alu_b = imm_s;
      OP_BR: alu_op = ALU_SUB;
      default: alu_op = ALU_ADD;
    endcase
  end

  mc_alu u_alu (.a(a_q), .b(alu_b), .op(alu_op), .y(alu_y), .zero(alu_zero));

  assign pc_plus4 = pc + 32'd4;
  assign taken    = (f3 == 3'b000) ? alu_zero : !alu_zero;
  assign mem_done = mem_req && mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (pc[1:0] != 2'b0) state_nx = S_TRAP;
                else if (mem_ready) state_nx = S_DECODE;
      S_DECODE: state_nx = illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (opcode == OP_LW || opcode == OP_SW)     state_nx = S_MEM;
        else if (opcode == OP_R || opcode == OP_I)  state_nx = S_WB;
        else                                        state_nx = S_FETCH;
      end
      S_MEM:    if (alu_out[1:0] != 2'b0) state_nx = S_TRAP;
                else if (mem_ready) state_nx = (opcode == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_nx = S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_FETCH;
    endcase
  end

  // memory port depends only on registered state, so it holds steady across waits
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    mem_wdata = 32'd0;
    halted    = 1'b0;
    case (state)
      S_FETCH: mem_req = (pc[1:0] == 2'b0);
      S_MEM: begin
        mem_req   = (alu_out[1:0] == 2'b0);
        mem_addr  = alu_out;
        mem_we    = (opcode == OP_SW);
        mem_wdata = b_q;
      end
      S_TRAP:  halted = 1'b1;
      default: mem_req = 1'b0;
    endcase
  end

  always_comb begin
    rf_wr = '{we: 1'b0, addr: rd, data: 32'd0};
    if (state == S_EXEC && opcode == OP_JAL) rf_wr = '{we: 1'b1, addr: rd, data: pc_plus4};
    if (state == S_EXEC && opcode == OP_LUI) rf_wr = '{we: 1'b1, addr: rd, data: imm_u};
    if (state == S_WB) rf_wr = '{we: 1'b1, addr: rd, data: (opcode == OP_LW) ? mdr : alu_out};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= 32'd0;
    end else if (rf_wr.we && rf_wr.addr != 5'd0) begin
      rf[rf_wr.addr[RW-1:0]] <= rf_wr.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
    end else begin
      case (state)
        S_FETCH:  if (mem_done) ir <= mem_rdata;
        S_DECODE: begin
          a_q <= rs1_val;
          b_q <= rs2_val;
        end
        S_EXEC: begin
          case (opcode)
            OP_LW, OP_SW, OP_R, OP_I: alu_out <= alu_y;
            OP_BR:   pc <= taken ? pc + imm_b : pc_plus4;
            OP_JAL:  pc <= pc + imm_j;
            OP_LUI:  pc <= pc_plus4;
            default: pc <= pc;
          endcase
        end
        S_MEM: begin
          if (mem_done && opcode == OP_LW) mdr <= mem_rdata;
          if (mem_done && opcode == OP_SW) pc <= pc_plus4;
        end
        S_WB:    pc <= pc_plus4;
        default: pc <= pc;
      endcase
    end
  end

`ifdef MULTICYCLE_RISCV_PERF_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= 32'd0;
      ret_q <= 32'd0;
    end else begin
      if (state != S_TRAP) cyc_q <= cyc_q + 32'd1;
      if ((state == S_EXEC || state == S_MEM || state == S_WB) && state_nx == S_FETCH)
        ret_q <= ret_q + 32'd1;
    end
  end

  assign perf_cycles  = cyc_q;
  assign perf_instret = ret_q;
`else
  assign perf_cycles  = 32'h0;
  assign perf_instret = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_riscv.sv
// Directed bench for multicycle_riscv: programs in a word memory with configurable wait states.
module tb_multicycle_riscv;

  logic        clk, reset;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, perf_cycles, perf_instret;

  multicycle_riscv #(.RESET_PC(32'h100), .NREGS(16)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted),
    .perf_cycles(perf_cycles), .perf_instret(perf_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // program image (initial block only) plus a store overlay (monitor only)
  logic [31:0] mem  [256];
  logic [31:0] dmem [256];
  bit   [255:0] dvalid;
  int          wait_n, wcnt, cyc, waits, viol;
  int unsigned acc [256];
  logic        pend, p_we;
  logic [31:0] p_addr, p_wdata;
  logic [31:0] st_addr[$], st_data[$];
  int          total, passed, failed;

  assign mem_ready = mem_req && (wcnt == wait_n);
  assign mem_rdata = dvalid[mem_addr[9:2]] ? dmem[mem_addr[9:2]] : mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (reset) begin
      cyc <= 0; wcnt <= 0; waits <= 0; viol <= 0; pend <= 1'b0; dvalid <= '0;
      st_addr.delete(); st_data.delete();
      for (int i = 0; i < 256; i++) acc[i] <= 0;
    end else begin
      cyc <= cyc + 1;
      wcnt <= (!mem_req || mem_ready) ? 0 : wcnt + 1;
      if (mem_req && !mem_ready) waits <= waits + 1;
      if (pend && mem_req && {mem_addr, mem_we, mem_wdata} != {p_addr, p_we, p_wdata}) viol <= viol + 1;
      pend <= mem_req && !mem_ready;
      p_addr <= mem_addr; p_we <= mem_we; p_wdata <= mem_wdata;
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          dmem[mem_addr[9:2]] <= mem_wdata;
          dvalid[mem_addr[9:2]] <= 1'b1;
          st_addr.push_back(mem_addr);
          st_data.push_back(mem_wdata);
        end else begin
          acc[mem_addr[9:2]] <= cyc + 1;
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [31:0] ILL = 32'h0000_007F;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]] = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_halt(input string tag);
    int n = 0;
    while (!halted && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_halted"}, {31'b0, halted}, 32'd1);
  endtask

  task automatic basic_prog();
    clear_mem();
    put(32'h100, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI));          // ADDI x1,x0,5
    put(32'h104, enc_r(7'b0, 5'd1, 5'd1, 3'b000, 5'd2));          // ADD  x2,x1,x1
    put(32'h108, enc_sw(12'h200, 5'd2, 5'd0));                    // SW   x2,0x200(x0)
    put(32'h10C, 32'hFFFF_FFFF);
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    reset = 1'b1; wait_n = 0;

    // 1: reset state, ADDI/ADD timing, zero wait
    basic_prog();
    @(posedge clk); #1;
    check("rst_req",   {31'b0, mem_req}, 32'd1);
    check("rst_we",    {31'b0, mem_we},  32'd0);
    check("rst_addr",  mem_addr, 32'h100);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    @(negedge clk); reset = 1'b0;
    run_halt("p1");
    check("p1_addi_cyc", acc[32'h104 >> 2] - acc[32'h100 >> 2], 32'd4);
    check("p1_add_cyc",  acc[32'h108 >> 2] - acc[32'h104 >> 2], 32'd4);
    check("p1_nst",      32'(st_addr.size()), 32'd1);
    check("p1_st_addr",  st_addr[0], 32'h200);
    check("p1_st_data",  st_data[0], 32'd10);
    check("p1_trap_req", {31'b0, mem_req}, 32'd0);
    check("p1_trap_pc",  mem_addr, 32'h10C);

    // 2: SW/LW with three wait states on every access
    clear_mem();
    put(32'h100, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI));
    put(32'h104, enc_r(7'b0, 5'd1, 5'd1, 3'b000, 5'd2));
    put(32'h108, enc_sw(12'd8, 5'd2, 5'd0));                      // SW x2,8(x0)
    put(32'h10C, enc_i(12'd8, 5'd0, 3'b010, 5'd3, 7'b0000011));   // LW x3,8(x0)
    put(32'h110, enc_sw(12'h204, 5'd3, 5'd0));                    // SW x3,0x204(x0)
    put(32'h114, ILL);
    wait_n = 3;
    do_reset();
    run_halt("p2");
    check("p2_nst",      32'(st_addr.size()), 32'd2);
    check("p2_sw_addr",  st_addr[0], 32'd8);
    check("p2_sw_data",  st_data[0], 32'd10);
    check("p2_lw_data",  st_data[1], 32'd10);
    check("p2_add_cyc",  acc[32'h108 >> 2] - acc[32'h104 >> 2], 32'd7);
    check("p2_lw_cyc",   acc[32'h110 >> 2] - acc[32'h10C >> 2], 32'd11);
    check("p2_waits_seen", {31'b0, waits > 20}, 32'd1);
    check("p2_stable",   32'(viol), 32'd0);
    wait_n = 0;

    // 3: branches
    clear_mem();
    put(32'h100, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI));
    put(32'h104, enc_b(13'd8, 5'd0, 5'd1, 3'b001));               // BNE x1,x0,+8
    put(32'h108, ILL);
    put(32'h10C, enc_b(13'd8, 5'd1, 5'd1, 3'b000));               // BEQ x1,x1,+8
    put(32'h110, ILL);
    put(32'h114, enc_b(13'd8, 5'd0, 5'd1, 3'b000));               // BEQ x1,x0 (not taken)
    put(32'h118, ILL);
    do_reset();
    run_halt("p3");
    check("p3_bne_cyc",  acc[32'h10C >> 2] - acc[32'h104 >> 2], 32'd3);
    check("p3_beq_cyc",  acc[32'h114 >> 2] - acc[32'h10C >> 2], 32'd3);
    check("p3_nt_cyc",   acc[32'h118 >> 2] - acc[32'h114 >> 2], 32'd3);
    check("p3_skip108",  acc[32'h108 >> 2], 32'd0);
    check("p3_trap_pc",  mem_addr, 32'h118);

    // 4: JAL link, x0 discard, LUI
    clear_mem();
    put(32'h100, enc_j(21'h1FFF20, 5'd0));                        // JAL x0,-0xE0 -> 0x20
    put(32'h020, enc_j(21'd16, 5'd1));                            // JAL x1,+16
    put(32'h030, enc_i(12'd7, 5'd0, 3'b000, 5'd0, OPI));          // ADDI x0,x0,7
    put(32'h034, {20'hABCDE, 5'd5, 7'b0110111});                  // LUI x5,0xABCDE
    put(32'h038, enc_sw(12'h208, 5'd1, 5'd0));
    put(32'h03C, enc_sw(12'h20C, 5'd0, 5'd0));
    put(32'h040, enc_sw(12'h210, 5'd5, 5'd0));
    put(32'h044, ILL);
    do_reset();
    run_halt("p4");
    check("p4_jal_cyc",  acc[32'h030 >> 2] - acc[32'h020 >> 2], 32'd3);
    check("p4_skip24",   acc[32'h024 >> 2], 32'd0);
    check("p4_nst",      32'(st_addr.size()), 32'd3);
    check("p4_link",     st_data[0], 32'h24);
    check("p4_x0",       st_data[1], 32'd0);
    check("p4_lui",      st_data[2], 32'hABCDE000);

    // 5: traps
    clear_mem(); put(32'h100, ILL);
    do_reset(); run_halt("p5_opc");
    check("p5_opc_req", {31'b0, mem_req}, 32'd0);
    check("p5_opc_pc",  mem_addr, 32'h100);
    clear_mem(); put(32'h100, enc_r(7'b0, 5'd1, 5'd1, 3'b000, 5'd20));
    do_reset(); run_halt("p5_rd20");
    check("p5_rd20_pc", mem_addr, 32'h100);
    clear_mem(); put(32'h100, enc_i(12'd2, 5'd0, 3'b010, 5'd3, 7'b0000011));
    do_reset(); run_halt("p5_mis");
    check("p5_mis_req", {31'b0, mem_req}, 32'd0);
    check("p5_mis_pc",  mem_addr, 32'h100);

    // 5b: reset in the middle of a wait-stated fetch
    basic_prog(); wait_n = 3;
    do_reset();
    begin
      int n = 0;
      while (!(mem_req && mem_addr == 32'h104) && n < 100) begin @(negedge clk); n++; end
      check("p5_reach104", mem_addr, 32'h104);
    end
    @(posedge clk); #2;
    reset = 1'b1; #1;
    check("p5_rst_addr", mem_addr, 32'h100);
    check("p5_rst_req",  {31'b0, mem_req}, 32'd1);
    @(posedge clk); @(negedge clk); reset = 1'b0;
    run_halt("p5_restart");
    check("p5_rs_nst",  32'(st_addr.size()), 32'd1);
    check("p5_rs_data", st_data[0], 32'd10);
    check("p5_rs_pc",   mem_addr, 32'h10C);
    wait_n = 0;

    // 6: performance counters over ten ADDIs
    clear_mem();
    for (int i = 0; i < 10; i++) put(32'h100 + 32'(4 * i), enc_i(12'd1, 5'd1, 3'b000, 5'd1, OPI));
    put(32'h128, ILL);
    do_reset();
    repeat (40) @(posedge clk);
    #1;
`ifdef MULTICYCLE_RISCV_PERF_EN
    check("p6_instret", perf_instret, 32'd10);
    check("p6_cycles",  perf_cycles, 32'd40);
`else
    check("p6_instret", perf_instret, 32'd0);
    check("p6_cycles",  perf_cycles, 32'd0);
`endif

    // 7: ALU mix: SRAI, SRLI, SUB, SLT, SLTU
    clear_mem();
    put(32'h100, enc_i(12'hFF0, 5'd0, 3'b000, 5'd1, OPI));        // ADDI x1,x0,-16
    put(32'h104, enc_i(12'h402, 5'd1, 3'b101, 5'd2, OPI));        // SRAI x2,x1,2
    put(32'h108, enc_i(12'h01C, 5'd1, 3'b101, 5'd3, OPI));        // SRLI x3,x1,28
    put(32'h10C, enc_r(7'b0100000, 5'd1, 5'd3, 3'b000, 5'd4));    // SUB  x4,x3,x1
    put(32'h110, enc_r(7'b0, 5'd3, 5'd1, 3'b010, 5'd6));          // SLT  x6,x1,x3
    put(32'h114, enc_r(7'b0, 5'd3, 5'd1, 3'b011, 5'd7));          // SLTU x7,x1,x3
    put(32'h118, enc_sw(12'h300, 5'd2, 5'd0));
    put(32'h11C, enc_sw(12'h304, 5'd3, 5'd0));
    put(32'h120, enc_sw(12'h308, 5'd4, 5'd0));
    put(32'h124, enc_sw(12'h30C, 5'd6, 5'd0));
    put(32'h128, enc_sw(12'h310, 5'd7, 5'd0));
    put(32'h12C, ILL);
    do_reset();
    run_halt("p7");
    check("p7_nst",  32'(st_addr.size()), 32'd5);
    check("p7_srai", st_data[0], 32'hFFFF_FFFC);
    check("p7_srli", st_data[1], 32'h0000_000F);
    check("p7_sub",  st_data[2], 32'h0000_001F);
    check("p7_slt",  st_data[3], 32'd1);
    check("p7_sltu", st_data[4], 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
